pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch-side controller that owns the program counter and sequences instruction fetch. It issues requests to instruction memory with a req/ack handshake and presents fetched instructions to the core with a valid/ready handshake. It applies branch/jump redirects, trap entry and halt. It sits between the core's next-PC logic and the instruction memory port, and supersedes the bare PC register for multi-cycle memories.

Parameters:
WIDTH, 64, PC/address width in bits
RESET_VECTOR, 64'h0, PC value loaded on reset
TRAP_VECTOR, 64'h100, PC value loaded on trap
INSTR_BYTES, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  WIDTH  fetch address; equals pc_out while imem_req=1
imem_ack  in  1  single-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr  out  32  captured instruction
instr_pc  out  WIDTH  address of instr
instr_ready  in  1  core accepts instr this cycle
redirect_valid  in  1  branch/jump taken
redirect_target  in  WIDTH  redirect address
trap  in  1  trap entry request
halt  in  1  stop fetching
halted  out  1  sequencer in HALTED
pc_out  out  WIDTH  current PC register

Behaviour:
- Reset low (async): state=BOOT, pc=RESET_VECTOR; imem_req, instr_valid, halted, pending flags = 0; instr, instr_pc = 0.
- States: BOOT, FETCH, HOLD, HALTED.
- BOOT: all outputs idle; next cycle -> FETCH (one-cycle gap after reset release).
- FETCH: imem_req=1, imem_addr=pc, both stable until ack. On ack with no pending event: instr<=imem_rdata, instr_pc<=pc, -> HOLD; instr_valid=1 from the next cycle.
- Events arriving in FETCH (trap, redirect, halt) cannot cancel the outstanding request. Record them in pending flags; a later event of higher priority overwrites a lower one. On ack: discard rdata (instr_valid stays 0) and apply the pending event. Pending trap/redirect: pc<=vector/target, remain FETCH, new address presented the cycle after ack. Pending halt: -> HALTED.
- HOLD: instr_valid=1; instr and instr_pc stable until accepted.
  - Priority each cycle: trap > redirect > halt > ready.
  - trap: pc<=TRAP_VECTOR, instr_valid->0, -> FETCH.
  - redirect: pc<=redirect_target with bits [1:0] forced 0, instr_valid->0, -> FETCH.
  - halt: if instr_ready=1, the instruction is accepted and pc<=pc+INSTR_BYTES. In either case -> HALTED.
  - instr_ready alone: pc<=pc+INSTR_BYTES, -> FETCH.
- Event in BOOT: trap/redirect update pc and the state still goes -> FETCH. Halt -> HALTED.
- HALTED: halted=1, imem_req=0, instr_valid=0. Ignores trap, redirect and halt; exits only via reset.
- Arithmetic: pc+INSTR_BYTES wraps modulo 2^WIDTH (all-ones minus 3 -> 0). No overflow flag.
- Reset asserted mid-fetch: the request is dropped immediately (imem_req=0 asynchronously). An ack arriving during or after reset before re-entering FETCH is ignored.
- Latency: ack at cycle N -> instr_valid=1 at N+1. Accept at cycle M -> imem_req=1 with the new address at M+1.
- imem_ack outside FETCH is ignored.

Test Plan:
- Reset release with 1-cycle ack memory, instr_ready=1 always -> imem_addr sequence 0x0, 0x4, 0x8; each instr_pc matches its address; instr_valid pulses one cycle after each ack.
- Core backpressure: instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, pc unchanged; ready=1 -> next fetch at pc+4.
- Redirect in HOLD to 0x1003 with instr_ready=1 same cycle -> instruction not consumed, next imem_addr=0x1000. Redirect during FETCH with 3-cycle ack latency -> rdata discarded, next address = target.
- Trap and redirect in the same HOLD cycle -> next imem_addr=0x100 (TRAP_VECTOR); the redirect is lost.
- pc=0xFFFF_FFFF_FFFF_FFFC accepted -> next imem_addr=0x0.
- halt during FETCH -> request completes, data discarded, halted=1, no further imem_req. Async reset mid-fetch -> imem_req drops the same cycle, pc=RESET_VECTOR.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch sequencer bus: instruction-memory req/ack port, core valid/ready
// port, and the control inputs (redirect, trap, halt) from the core.
interface pc_sequencer_if #(
  parameter int WIDTH = 64
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_ready;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             trap;
  logic             halt;
  logic             halted;
  logic [WIDTH-1:0] pc_out;

  // Sequencer side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, halted, pc_out,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target,
           trap, halt
  );

  // Memory / core side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted, pc_out,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target,
           trap, halt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side PC owner: issues one fetch at a time, holds the fetched word
// until the core takes it, and applies redirect / trap / halt.
module pc_sequencer #(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h100),
  parameter int               INSTR_BYTES  = 4
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, HALTED} state_t;
  // Encoded in priority order so a plain compare picks the stronger event.
  typedef enum logic [1:0] {EV_NONE, EV_HALT, EV_REDIR, EV_TRAP} ev_t;

  state_t           state;
  ev_t              pend, ev_now, ev_merged;
  logic [WIDTH-1:0] pc, pend_tgt, tgt_merged, tgt_aligned, pc_next_seq;
  logic             req, valid, halted_q;
  logic [31:0]      instr_q;
  logic [WIDTH-1:0] instr_pc_q;

  assign tgt_aligned = {bus.redirect_target[WIDTH-1:2], 2'b00};
  assign pc_next_seq = pc + WIDTH'(INSTR_BYTES);

  // Collapse this cycle's inputs to one event, then fold it into whatever
  // is already pending; an equal-or-stronger event replaces the old one.
  always_comb begin
    ev_now     = EV_NONE;
    ev_merged  = pend;
    tgt_merged = pend_tgt;
    if (bus.trap)                ev_now = EV_TRAP;
    else if (bus.redirect_valid) ev_now = EV_REDIR;
    else if (bus.halt)           ev_now = EV_HALT;
    if (ev_now != EV_NONE && ev_now >= pend) begin
      ev_merged  = ev_now;
      tgt_merged = tgt_aligned;
    end
  end

  // Sequencer FSM with registered outputs; reset drops imem_req at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      pend       <= EV_NONE;
      pend_tgt   <= '0;
      req        <= 1'b0;
      valid      <= 1'b0;
      halted_q   <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      case (state)
        BOOT: begin
          if (ev_now == EV_TRAP)       pc <= TRAP_VECTOR;
          else if (ev_now == EV_REDIR) pc <= tgt_aligned;
          if (ev_now == EV_HALT) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state <= FETCH;
            req   <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.imem_ack) begin
            pend <= EV_NONE;
            case (ev_merged)
              EV_NONE: begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
                valid      <= 1'b1;
                req        <= 1'b0;
                state      <= HOLD;
              end
              // Stay in FETCH; the new address goes out next cycle.
              EV_TRAP:  pc <= TRAP_VECTOR;
              EV_REDIR: pc <= tgt_merged;
              default: begin
                req      <= 1'b0;
                halted_q <= 1'b1;
                state    <= HALTED;
              end
            endcase
          end else begin
            pend     <= ev_merged;
            pend_tgt <= tgt_merged;
          end
        end
        HOLD: begin
          if (bus.trap) begin
            pc    <= TRAP_VECTOR;
            valid <= 1'b0;
            req   <= 1'b1;
            state <= FETCH;
          end else if (bus.redirect_valid) begin
            pc    <= tgt_aligned;
            valid <= 1'b0;
            req   <= 1'b1;
            state <= FETCH;
          end else if (bus.halt) begin
            if (bus.instr_ready) pc <= pc_next_seq;
            valid    <= 1'b0;
            halted_q <= 1'b1;
            state    <= HALTED;
          end else if (bus.instr_ready) begin
            pc    <= pc_next_seq;
            valid <= 1'b0;
            req   <= 1'b1;
            state <= FETCH;
          end
        end
        default: ; // HALTED: only reset leaves
      endcase
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.halted      = halted_q;
  assign bus.pc_out      = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then randomized traffic, all
// checked every cycle against a behavioural fetch model.
module tb_pc_sequencer;
  localparam int          W  = 64;
  localparam logic [W-1:0] RV = '0;
  localparam logic [W-1:0] TV = 64'h100;
  localparam int S_BOOT = 0, S_FETCH = 1, S_HOLD = 2, S_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(W)) b();

  pc_sequencer #(.WIDTH(W), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .INSTR_BYTES(4))
    dut (.clk(clk), .reset(rst_n), .bus(b));

  int n_vec = 0, n_err = 0;

  // Reference model: architectural phase, PC, held instruction, pending event
  int          m_st, m_pend;
  logic [W-1:0] m_pc, m_tgt, m_ipc;
  logic [31:0]  m_instr;

  // Stimulus knobs
  logic         ev_trap, ev_redir, ev_halt, rdy;
  logic [W-1:0] tgt;
  int           lat = 1, wcnt = 0;
  bit           spur_en = 0, rand_lat = 0;

  function automatic logic [31:0] memw(logic [W-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [W-1:0] al(logic [W-1:0] a);
    return {a[W-1:2], 2'b00};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of behaviour given the inputs that were applied
  task automatic model(logic ack);
    int ev;
    ev = ev_trap ? 3 : ev_redir ? 2 : ev_halt ? 1 : 0;
    case (m_st)
      S_BOOT: begin
        if (ev == 3) m_pc = TV;
        else if (ev == 2) m_pc = al(tgt);
        m_st = (ev == 1) ? S_HALT : S_FETCH;
      end
      S_FETCH: begin
        if (ev != 0 && ev >= m_pend) begin m_pend = ev; m_tgt = al(tgt); end
        if (ack) begin
          if (m_pend == 0) begin m_instr = memw(m_pc); m_ipc = m_pc; m_st = S_HOLD; end
          else if (m_pend == 3) m_pc = TV;
          else if (m_pend == 2) m_pc = m_tgt;
          else m_st = S_HALT;
          m_pend = 0;
        end
      end
      S_HOLD: begin
        if (ev == 3)      begin m_pc = TV; m_st = S_FETCH; end
        else if (ev == 2) begin m_pc = al(tgt); m_st = S_FETCH; end
        else if (ev == 1) begin if (rdy) m_pc += 4; m_st = S_HALT; end
        else if (rdy)     begin m_pc += 4; m_st = S_FETCH; end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("imem_req", b.imem_req, m_st == S_FETCH);
    if (m_st == S_FETCH) check("imem_addr", b.imem_addr, m_pc);
    check("instr_valid", b.instr_valid, m_st == S_HOLD);
    if (m_st == S_HOLD) begin
      check("instr", b.instr, m_instr);
      check("instr_pc", b.instr_pc, m_ipc);
    end
    check("halted", b.halted, m_st == S_HALT);
    check("pc_out", b.pc_out, m_pc);
  endtask

  // Drive inputs (memory responder included), clock once, model, compare
  task automatic step();
    logic        ack;
    logic [31:0] rd;
    b.trap            = ev_trap;
    b.redirect_valid  = ev_redir;
    b.redirect_target = tgt;
    b.halt            = ev_halt;
    b.instr_ready     = rdy;
    ack = 1'b0;
    rd  = $urandom;
    if (b.imem_req === 1'b1) begin
      if (wcnt + 1 >= lat) begin
        ack = 1'b1; rd = memw(b.imem_addr); wcnt = 0;
        if (rand_lat) lat = $urandom_range(1, 4);
      end else wcnt++;
    end else begin
      wcnt = 0;
      ack  = spur_en && ($urandom_range(0, 3) == 0);
    end
    b.imem_ack   = ack;
    b.imem_rdata = rd;
    @(posedge clk);
    model(ack);
    #1 compare_all();
  endtask

  task automatic clear_ev();
    ev_trap = 0; ev_redir = 0; ev_halt = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_ev();
    b.imem_ack = 1'b0;
    m_st = S_BOOT; m_pc = RV; m_pend = 0; m_instr = '0; m_ipc = '0; m_tgt = '0;
    wcnt = 0;
    #1;
    check("rst_req", b.imem_req, 1'b0);
    check("rst_valid", b.instr_valid, 1'b0);
    check("rst_halted", b.halted, 1'b0);
    check("rst_pc", b.pc_out, RV);
    check("rst_instr", b.instr, 32'h0);
    check("rst_instr_pc", b.instr_pc, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_hold();
    for (int i = 0; i < 20 && b.instr_valid !== 1'b1; i++) step();
    check("wait_hold", b.instr_valid, 1'b1);
  endtask

  initial begin
    b.imem_ack = 0; b.imem_rdata = 0; b.instr_ready = 0;
    b.redirect_valid = 0; b.redirect_target = 0; b.trap = 0; b.halt = 0;
    clear_ev(); rdy = 1; tgt = '0;
    apply_reset();

    // Sequential fetch, 1-cycle memory, core always ready
    lat = 1; rdy = 1;
    for (int i = 0; i < 6; i++) step();
    check("seq_instr_pc", b.instr_pc, 64'h8);

    // Backpressure for 5 cycles, then accept
    rdy = 0;
    repeat (5) step();
    check("bp_instr_pc", b.instr_pc, 64'h8);
    check("bp_pc", b.pc_out, 64'h8);
    rdy = 1; step();
    check("bp_next_addr", b.imem_addr, 64'hC);

    // Redirect in HOLD with ready the same cycle: instruction not consumed
    rdy = 0; wait_hold();
    ev_redir = 1; tgt = 64'h1003; rdy = 1; step(); clear_ev();
    check("redir_hold_addr", b.imem_addr, 64'h1000);

    // Redirect during a 3-cycle fetch: data dropped, next address = target
    lat = 3;
    ev_redir = 1; tgt = 64'h2000; step(); clear_ev();
    step(); step();
    check("redir_fetch_addr", b.imem_addr, 64'h2000);
    check("redir_fetch_valid", b.instr_valid, 1'b0);
    lat = 1;

    // Trap and redirect together in HOLD: trap wins
    rdy = 0; wait_hold();
    ev_trap = 1; ev_redir = 1; tgt = 64'h3000; step(); clear_ev();
    check("trap_wins", b.imem_addr, TV);

    // PC wrap at the top of the address space
    rdy = 0; wait_hold();
    ev_redir = 1; tgt = 64'hFFFF_FFFF_FFFF_FFFC; rdy = 1; step(); clear_ev();
    rdy = 0; wait_hold();
    check("wrap_instr_pc", b.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    rdy = 1; step();
    check("wrap_addr", b.imem_addr, 64'h0);

    // Halt during FETCH: request completes, then silence; events ignored
    lat = 3;
    ev_halt = 1; step(); clear_ev();
    step(); step();
    check("halt_fetch", b.halted, 1'b1);
    ev_trap = 1; ev_redir = 1; tgt = 64'h4000; step(); step(); clear_ev();
    repeat (4) step();
    check("halt_no_req", b.imem_req, 1'b0);

    // Async reset in the middle of an outstanding fetch
    apply_reset();
    lat = 10;
    step(); step();
    check("mid_req_before", b.imem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_req_drop", b.imem_req, 1'b0);
    check("async_pc", b.pc_out, RV);
    apply_reset();
    lat = 1;

    // Randomized traffic: events, latencies, backpressure, stray acks
    spur_en = 1; rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      ev_trap  = ($urandom_range(0, 39) == 0);
      ev_redir = ($urandom_range(0, 14) == 0);
      ev_halt  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0)
        tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
      else
        tgt = {$urandom, $urandom & 32'hFFFF_FFFC};
      rdy = ($urandom_range(0, 2) != 0);
      step();
      if (m_st == S_HALT && $urandom_range(0, 9) == 0) apply_reset();
    end
    clear_ev();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
